// File: rtl/adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter
//
// Shares one registered WIDTH-bit adder between NUM_REQ requesters. A
// round-robin arbiter picks one pending requester per cycle whenever the
// single result register is free or being drained. The winner's sum, carry
// and ID come out of that register one cycle after acceptance.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   req_valid    per-requester "operand pair pending"
//   req_a/req_b  packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready    one-hot grant, combinational
//   rsp_valid    result register holds a result
//   rsp_ready    consumer takes the result this cycle
//   rsp_sum      (a + b) mod 2^WIDTH
//   rsp_carry    carry-out of a + b
//   rsp_id       index of the requester that produced the result
//   grant_count  wrapping count of accepted requests
// -----------------------------------------------------------------------------
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic [IDW-1:0]           rsp_id,
  output logic [7:0]               grant_count
);

  // Unsigned add at WIDTH+1 bits so the carry-out is the top bit.
  function automatic logic [WIDTH:0] add_with_carry(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  logic [IDW-1:0]   rr_ptr;
  logic             found_p0;
  logic [IDW-1:0]   gidx_p0;
  logic             can_issue_p0;
  logic             grant_p0;
  logic [WIDTH:0]   wide_sum_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] sum_p1;
  logic             carry_p1;
  logic [IDW-1:0]   id_p1;
  logic [7:0]       count_p1;

  // ---- Stage p0: round-robin selection and operand mux ----
  // Search starts at rr_ptr and wraps modulo NUM_REQ, which need not be a
  // power of two, so the wrap is done in integer arithmetic.
  always_comb begin
    int idx;
    found_p0 = 1'b0;
    gidx_p0  = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found_p0 && req_valid[IDW'(idx)]) begin
        found_p0 = 1'b1;
        gidx_p0  = IDW'(idx);
      end
    end
  end

  // Reset is folded in so no grant is advertised while reset is held.
  assign can_issue_p0 = !vld_p1 || rsp_ready;
  assign grant_p0     = can_issue_p0 && found_p0 && !reset;
  assign req_ready    = grant_p0 ? (NUM_REQ'(1) << gidx_p0) : '0;
  assign wide_sum_p0  = add_with_carry(a_arr[gidx_p0], b_arr[gidx_p0]);

  // ---- Stage p1: result register, pointer and grant counter ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      sum_p1   <= '0;
      carry_p1 <= 1'b0;
      id_p1    <= '0;
      count_p1 <= '0;
      rr_ptr   <= '0;
    end else if (grant_p0) begin
      vld_p1   <= 1'b1;
      sum_p1   <= wide_sum_p0[WIDTH-1:0];
      carry_p1 <= wide_sum_p0[WIDTH];
      id_p1    <= gidx_p0;
      count_p1 <= count_p1 + 8'd1;
      if (gidx_p0 == IDW'(NUM_REQ - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= gidx_p0 + 1'b1;
      end
    end else if (rsp_ready) begin
      // Drained with nothing to refill: data fields keep their stale values.
      vld_p1 <= 1'b0;
    end
  end

  assign rsp_valid   = vld_p1;
  assign rsp_sum     = sum_p1;
  assign rsp_carry   = carry_p1;
  assign rsp_id      = id_p1;
  assign grant_count = count_p1;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arbiter
//
// Self-checking bench for adder_share_arbiter (NUM_REQ=4, WIDTH=4). A
// behavioural model holds the expected result register contents, pointer and
// grant count as plain integers; each scenario task drives stimulus and
// compares the DUT against that model or against fixed expected values.
// -----------------------------------------------------------------------------
module tb_adder_share_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0] req_ready;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_sum;
  logic         rsp_carry;
  logic [1:0]   rsp_id;
  logic [7:0]   grant_count;

  int n_pass  = 0;
  int n_total = 0;

  // Model state
  int m_vld, m_sum, m_carry, m_id, m_ptr, m_cnt;

  adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .rsp_id(rsp_id), .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = pick(req_valid, m_ptr);
    if (reset || !(m_vld == 0 || rsp_ready) || g < 0) return '0;
    return N'(1) << g;
  endfunction

  task automatic model_clear();
    m_vld = 0; m_sum = 0; m_carry = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_ops(i, $urandom_range(0, 15), $urandom_range(0, 15));
  endtask

  // Advance one clock edge and apply the accept/drain rules to the model.
  task automatic tick();
    int g, s;
    bit can;
    can = (m_vld == 0) || rsp_ready;
    g = pick(req_valid, m_ptr);
    @(posedge clk);
    if (can && g >= 0) begin
      s = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
      m_sum = s % 16; m_carry = s / 16; m_id = g; m_vld = 1;
      m_ptr = (g + 1) % N; m_cnt = (m_cnt + 1) % 256;
    end else if (rsp_ready) begin
      m_vld = 0;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111; rsp_ready = 1'b1; rand_ops();
    model_clear();
    @(posedge clk);
    #1;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready actual=%b required=0000", req_ready); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid actual=%b required=0", rsp_valid); else n_pass++;
    n_total++; if ({rsp_sum, rsp_carry, rsp_id} !== '0) $display("FAIL reset_data actual=%h/%b/%0d required=0", rsp_sum, rsp_carry, rsp_id); else n_pass++;
    n_total++; if (grant_count !== 8'd0) $display("FAIL reset_count actual=%0d required=0", grant_count); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL reset_first_grant actual=%b required=0001", req_ready); else n_pass++;
  endtask

  task automatic test_single();
    apply_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0001; set_ops(0, 3, 5);
    #1;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL single0_ready actual=%b required=0001", req_ready); else n_pass++;
    tick();
    req_valid = 4'b0000;
    n_total++; if ({rsp_valid, rsp_sum, rsp_carry, rsp_id} !== {1'b1, 4'd8, 1'b0, 2'd0}) $display("FAIL single0_rsp actual=v%b s%0d c%b id%0d required=v1 s8 c0 id0", rsp_valid, rsp_sum, rsp_carry, rsp_id); else n_pass++;
    n_total++; if (grant_count !== 8'd1) $display("FAIL single0_count actual=%0d required=1", grant_count); else n_pass++;
    req_valid = 4'b0100; set_ops(2, 9, 9);
    #1;
    n_total++; if (req_ready !== 4'b0100) $display("FAIL single2_ready actual=%b required=0100", req_ready); else n_pass++;
    tick();
    n_total++; if ({rsp_valid, rsp_sum, rsp_carry, rsp_id} !== {1'b1, 4'd2, 1'b1, 2'd2}) $display("FAIL single2_rsp actual=v%b s%0d c%b id%0d required=v1 s2 c1 id2", rsp_valid, rsp_sum, rsp_carry, rsp_id); else n_pass++;
    req_valid = 4'b0010; set_ops(1, 15, 15);
    tick();
    req_valid = 4'b0000;
    n_total++; if ({rsp_valid, rsp_sum, rsp_carry, rsp_id} !== {1'b1, 4'd14, 1'b1, 2'd1}) $display("FAIL single1_rsp actual=v%b s%0d c%b id%0d required=v1 s14 c1 id1", rsp_valid, rsp_sum, rsp_carry, rsp_id); else n_pass++;
    tick();
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL drain_valid actual=%b required=0", rsp_valid); else n_pass++;
    n_total++; if (grant_count !== 8'd3) $display("FAIL drain_count actual=%0d required=3", grant_count); else n_pass++;
  endtask

  task automatic test_round_robin();
    apply_reset();
    rsp_ready = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      #1;
      n_total++; if (req_ready !== (N'(1) << (i % N))) $display("FAIL rr_ready step=%0d actual=%b required=%b", i, req_ready, N'(1) << (i % N)); else n_pass++;
      tick();
      n_total++; if (rsp_valid !== 1'b1 || int'(rsp_id) !== i % N) $display("FAIL rr_rsp step=%0d actual=v%b id%0d required=v1 id%0d", i, rsp_valid, rsp_id, i % N); else n_pass++;
      n_total++; if (int'(rsp_sum) !== m_sum || int'(rsp_carry) !== m_carry) $display("FAIL rr_sum step=%0d actual=%0d/%b required=%0d/%0d", i, rsp_sum, rsp_carry, m_sum, m_carry); else n_pass++;
    end
  endtask

  // Follows test_round_robin: a result is pending and the pointer sits at 2.
  task automatic test_backpressure();
    rsp_ready = 1'b0; req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      #1;
      n_total++; if (req_ready !== 4'b0000) $display("FAIL bp_ready cyc=%0d actual=%b required=0000", i, req_ready); else n_pass++;
      tick();
      n_total++; if (rsp_valid !== 1'b1 || int'(rsp_sum) !== m_sum || int'(rsp_carry) !== m_carry || int'(rsp_id) !== m_id) $display("FAIL bp_hold cyc=%0d actual=v%b s%0d c%b id%0d required=v1 s%0d c%0d id%0d", i, rsp_valid, rsp_sum, rsp_carry, rsp_id, m_sum, m_carry, m_id); else n_pass++;
      n_total++; if (grant_count !== 8'd6) $display("FAIL bp_count cyc=%0d actual=%0d required=6", i, grant_count); else n_pass++;
    end
    rsp_ready = 1'b1;
    #1;
    n_total++; if (req_ready !== 4'b0100) $display("FAIL bp_release_ready actual=%b required=0100", req_ready); else n_pass++;
    tick();
    n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || int'(rsp_sum) !== m_sum) $display("FAIL bp_release_rsp actual=v%b id%0d s%0d required=v1 id2 s%0d", rsp_valid, rsp_id, rsp_sum, m_sum); else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rsp_ready = 1'b1; req_valid = 4'b1111; rand_ops();
    tick();
    tick();
    #2 reset = 1'b1;
    model_clear();
    #1;
    n_total++; if ({rsp_valid, rsp_sum, rsp_carry, rsp_id, grant_count, req_ready} !== '0) $display("FAIL midreset_outputs actual=v%b s%0d c%b id%0d cnt%0d rdy%b required=all0", rsp_valid, rsp_sum, rsp_carry, rsp_id, grant_count, req_ready); else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL midreset_first_grant actual=%b required=0001", req_ready); else n_pass++;
    tick();
    n_total++; if (rsp_id !== 2'd0 || grant_count !== 8'd1) $display("FAIL midreset_first_rsp actual=id%0d cnt%0d required=id0 cnt1", rsp_id, grant_count); else n_pass++;
  endtask

  task automatic test_count_wrap();
    apply_reset();
    rsp_ready = 1'b1; req_valid = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      set_ops(0, $urandom_range(0, 15), $urandom_range(0, 15));
      tick();
    end
    n_total++; if (grant_count !== 8'd0 || rsp_valid !== 1'b1) $display("FAIL wrap_256 actual=cnt%0d v%b required=cnt0 v1", grant_count, rsp_valid); else n_pass++;
    tick();
    n_total++; if (grant_count !== 8'd1) $display("FAIL wrap_257 actual=%0d required=1", grant_count); else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      #1;
      n_total++; if (req_ready !== exp_ready()) $display("FAIL rand_ready cyc=%0d actual=%b required=%b", i, req_ready, exp_ready()); else n_pass++;
      tick();
      n_total++; if (int'(rsp_valid) !== m_vld || int'(grant_count) !== m_cnt) $display("FAIL rand_state cyc=%0d actual=v%b cnt%0d required=v%0d cnt%0d", i, rsp_valid, grant_count, m_vld, m_cnt); else n_pass++;
      if (m_vld != 0) begin
        n_total++; if (int'(rsp_sum) !== m_sum || int'(rsp_carry) !== m_carry || int'(rsp_id) !== m_id) $display("FAIL rand_rsp cyc=%0d actual=s%0d c%b id%0d required=s%0d c%0d id%0d", i, rsp_sum, rsp_carry, rsp_id, m_sum, m_carry, m_id); else n_pass++;
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_count_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
